// File: rtl/dac_wave_seq.sv
// dac_wave_seq: waveform sequencer (ramp / triangle / square / constant) that
// feeds a DAC writer one 12-bit sample at a time, using a set/busy handshake.
module dac_wave_seq #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [11:0]         level_lo,
  input  logic [11:0]         level_hi,
  input  logic [11:0]         step,
  input  logic [PERIOD_W-1:0] period,
  input  logic                dac_busy,
  output logic [11:0]         dac,
  output logic                set,
  output logic                active,
  output logic                overrun,
  output logic                cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_WAIT_TICK
  } state_e;

  typedef enum logic [1:0] {
    M_RAMP   = 2'd0,
    M_TRI    = 2'd1,
    M_SQUARE = 2'd2,
    M_CONST  = 2'd3
  } mode_e;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [11:0]           lo_q, lo_d;
  logic [11:0]           hi_q, hi_d;
  logic [11:0]           step_q, step_d;
  logic [PERIOD_W-1:0]   per_m1_q, per_m1_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [1:0]            ack_cnt_q, ack_cnt_d;
  logic [11:0]           val_q, val_d;
  logic                  dir_up_q, dir_up_d;
  logic [11:0]           dac_q, dac_d;
  logic                  set_q, set_d;
  logic                  active_q, active_d;
  logic                  overrun_q, overrun_d;

  logic                  start;
  logic                  tick;
  logic [12:0]           sum13;
  logic [12:0]           lo_step13;
  logic [11:0]           nxt_val;
  logic                  nxt_dir_up;

  // Bounds are only meaningful as latched; an inverted pair forces lo samples.
  assign cfg_err = (lo_q > hi_q);

  assign start = (state_q == S_IDLE) && enable && !dac_busy;
  assign tick  = (state_q != S_IDLE) && (cnt_q == per_m1_q);

  assign dac     = dac_q;
  assign set     = set_q;
  assign active  = active_q;
  assign overrun = overrun_q;

  // Sample-period counter: free-running outside IDLE, restarted on each run start.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      if (start) cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // Next sample value; 13-bit sums keep the comparisons free of 12-bit wrap.
  always_comb begin
    sum13      = {1'b0, val_q} + {1'b0, step_q};
    lo_step13  = {1'b0, lo_q} + {1'b0, step_q};
    nxt_val    = lo_q;
    nxt_dir_up = dir_up_q;
    if (!cfg_err) begin
      unique case (mode_q)
        M_RAMP: begin
          if (step_q != '0 && sum13 <= {1'b0, hi_q}) nxt_val = sum13[11:0];
        end
        M_TRI: begin
          if (step_q == '0) begin
            nxt_dir_up = 1'b1;
          end else if (dir_up_q) begin
            if (sum13 >= {1'b0, hi_q}) begin
              nxt_val    = hi_q;
              nxt_dir_up = 1'b0;
            end else begin
              nxt_val = sum13[11:0];
            end
          end else if ({1'b0, val_q} < lo_step13) begin
            nxt_dir_up = 1'b1;
          end else begin
            nxt_val = val_q - step_q;
          end
        end
        M_SQUARE: begin
          // dir_up doubles as the square phase: up means the next sample is hi.
          nxt_val    = dir_up_q ? hi_q : lo_q;
          nxt_dir_up = !dir_up_q;
        end
        default: nxt_val = lo_q;
      endcase
    end
  end

  // Sequencer FSM: next state, config latch, sample update and output strobes.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    per_m1_d  = per_m1_q;
    ack_cnt_d = ack_cnt_q;
    val_d     = val_q;
    dir_up_d  = dir_up_q;
    dac_d     = dac_q;
    set_d     = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          lo_d      = level_lo;
          hi_d      = level_hi;
          step_d    = step;
          per_m1_d  = (period == '0) ? '0 : period - PERIOD_W'(1);
          overrun_d = 1'b0;
          val_d     = level_lo;
          dir_up_d  = 1'b1;
          dac_d     = level_lo;
          set_d     = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A writer that never raises busy is treated as done after four cycles.
        if (dac_busy || ack_cnt_q == 2'd3) begin
          state_d = S_WAIT_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 2'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!dac_busy) begin
          val_d    = nxt_val;
          dir_up_d = nxt_dir_up;
          state_d  = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (dac_busy) begin
            // Never strobe into a busy writer; the tick is lost like any other.
            overrun_d = 1'b1;
          end else begin
            dac_d   = val_q;
            set_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tick && (state_q == S_ISSUE || state_q == S_WAIT_ACK || state_q == S_WAIT_DONE)) begin
      overrun_d = 1'b1;
    end
  end

  assign active_d = (state_d != S_IDLE);

  // State and datapath registers; everything returns to its idle value on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= M_RAMP;
      lo_q      <= '0;
      hi_q      <= '0;
      step_q    <= '0;
      per_m1_q  <= '0;
      cnt_q     <= '0;
      ack_cnt_q <= '0;
      val_q     <= '0;
      dir_up_q  <= 1'b1;
      dac_q     <= '0;
      set_q     <= 1'b0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      step_q    <= step_d;
      per_m1_q  <= per_m1_d;
      cnt_q     <= cnt_d;
      ack_cnt_q <= ack_cnt_d;
      val_q     <= val_d;
      dir_up_q  <= dir_up_d;
      dac_q     <= dac_d;
      set_q     <= set_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_dac_wave_seq.sv
// tb_dac_wave_seq: scoreboard bench for dac_wave_seq with a behavioural DAC writer.
module tb_dac_wave_seq;

  localparam int PERIOD_W = 16;
  localparam int LIMIT    = 5000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic [1:0]          mode = '0;
  logic [11:0]         level_lo = '0;
  logic [11:0]         level_hi = '0;
  logic [11:0]         step = '0;
  logic [PERIOD_W-1:0] period = '0;
  logic                dac_busy;
  logic [11:0]         dac;
  logic                set;
  logic                active;
  logic                overrun;
  logic                cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int wr_len = 0;
  int busy_cnt = 0;

  int q_exp[$];
  int exp_gap = 0;
  int exp_cfg = 0;
  bit first_set = 1'b1;
  int last_set_cyc = 0;
  int sets_seen = 0;
  int run_base = 0;
  logic [11:0] last_dac = '0;
  logic set_prev = 1'b0;

  dac_wave_seq #(.PERIOD_W(PERIOD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode     (mode),
    .level_lo (level_lo),
    .level_hi (level_hi),
    .step     (step),
    .period   (period),
    .dac_busy (dac_busy),
    .dac      (dac),
    .set      (set),
    .active   (active),
    .overrun  (overrun),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural writer: busy for wr_len cycles after each set; wr_len=0 never acks.
  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (set && wr_len > 0) busy_cnt <= wr_len;
  end
  assign dac_busy = (busy_cnt > 0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference sample sequence built straight from the waveform rules.
  task automatic push_exp(input int m, input int lo, input int hi, input int st, input int n);
    int v;
    bit up;
    v  = lo;
    up = 1'b1;
    for (int i = 0; i < n; i++) begin
      q_exp.push_back(v);
      if (lo > hi) begin
        v = lo;
      end else begin
        case (m)
          0: v = (v + st > hi) ? lo : v + st;
          1: begin
            if (up) begin
              if (v + st >= hi) begin v = hi; up = 1'b0; end
              else v = v + st;
            end else begin
              if (v < lo + st) begin v = lo; up = 1'b1; end
              else v = v - st;
            end
          end
          2: begin v = up ? hi : lo; up = !up; end
          default: v = lo;
        endcase
      end
    end
  endtask

  // Monitor: every set pops one expected sample and checks handshake/timing rules.
  always @(negedge clk) begin
    int e;
    if (rst_n && dac_busy) check("dac_hold", dac, last_dac);
    last_dac = dac;
    if (set) begin
      check("set_width", set_prev, 0);
      check("set_busy", dac_busy, 0);
      check("cfg_err", cfg_err, exp_cfg);
      if (q_exp.size() == 0) begin
        check("unexpected_set", 1, 0);
      end else begin
        e = q_exp.pop_front();
        check("dac", dac, e);
      end
      if (!first_set && exp_gap > 0) check("set_gap", cyc - last_set_cyc, exp_gap);
      first_set = 1'b0;
      last_set_cyc = cyc;
      sets_seen++;
    end
    set_prev = set;
  end

  task automatic wait_quiet();
    int g;
    g = 0;
    while ((dac_busy || active) && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    if (g >= LIMIT) check("timeout_quiet", 0, 1);
  endtask

  task automatic start_run(input int m, input int lo, input int hi, input int st,
                           input int per, input int n, input int wl, input int gap);
    wait_quiet();
    mode     = 2'(m);
    level_lo = 12'(lo);
    level_hi = 12'(hi);
    step     = 12'(st);
    period   = PERIOD_W'(per);
    wr_len   = wl;
    exp_gap  = gap;
    exp_cfg  = (lo > hi) ? 1 : 0;
    first_set = 1'b1;
    run_base = sets_seen;
    push_exp(m, lo, hi, st, n);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency", set, 1);
  endtask

  task automatic finish_run(input int n, input int exp_ovr);
    int g;
    g = 0;
    while (sets_seen - run_base < n && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    if (g >= LIMIT) check("timeout_sets", 0, 1);
    enable = 1'b0;
    wait_quiet();
    check("queue_empty", q_exp.size(), 0);
    check("overrun", overrun, exp_ovr);
  endtask

  initial begin
    int g;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dac", dac, 0);
    check("rst_set", set, 0);
    check("rst_active", active, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp: 0,1024,2048,3072,0 at 200-clock spacing.
    start_run(0, 0, 4095, 1024, 200, 5, 10, 200);
    finish_run(5, 0);

    // Triangle: 100,250,400,250,100 at 300-clock spacing.
    start_run(1, 100, 400, 150, 300, 5, 10, 300);
    finish_run(5, 0);

    // Square, then constant with a writer that never acks (WAIT_ACK timeout).
    start_run(2, 10, 20, 5, 20, 4, 5, 20);
    finish_run(4, 0);
    start_run(3, 10, 20, 5, 20, 3, 0, 20);
    finish_run(3, 0);

    // Inverted bounds: cfg_err high and every sample is lo.
    start_run(2, 30, 20, 5, 20, 3, 5, 20);
    finish_run(3, 0);
    check("cfg_err_held", cfg_err, 1);

    // period=0 acts as 1: ISSUE, 4 WAIT_ACK, WAIT_DONE, WAIT_TICK -> 7-clock spacing.
    start_run(2, 10, 20, 5, 0, 3, 0, 7);
    finish_run(3, 1);

    // Overrun: period 5 with 50-clock writes; busy drops at +51, ticks at +49/+54,
    // so the next set lands at +55.
    start_run(0, 0, 100, 10, 5, 3, 50, 55);
    finish_run(3, 1);

    // Enable dropped mid-write: active holds until busy falls, no further set.
    start_run(0, 5, 4000, 10, 5, 1, 50, 0);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    check("drop_active_busy", active, 1);
    g = 0;
    while (dac_busy && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    if (g >= LIMIT) check("timeout_busy", 0, 1);
    check("drop_active_at_fall", active, 1);
    repeat (3) @(negedge clk);
    check("drop_active_low", active, 0);
    check("drop_overrun", overrun, 1);
    check("drop_queue", q_exp.size(), 0);

    // Re-enable restarts at lo with overrun cleared.
    start_run(0, 300, 900, 100, 200, 2, 10, 200);
    check("reenable_overrun", overrun, 0);
    finish_run(2, 0);

    // Reset during WAIT_DONE: outputs clear at once; restart one cycle after release.
    start_run(3, 77, 100, 0, 200, 1, 50, 0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_dac", dac, 0);
    check("rst_mid_set", set, 0);
    check("rst_mid_active", active, 0);
    check("rst_mid_overrun", overrun, 0);
    g = 0;
    while (dac_busy && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    if (g >= LIMIT) check("timeout_rst_busy", 0, 1);
    @(negedge clk);
    first_set = 1'b1;
    run_base = sets_seen;
    q_exp.push_back(77);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_restart_set", set, 1);
    finish_run(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
